key_led_seq: RTL
================

// Module: key_led_seq
// PURPOSE
//  Parametrised, clocked successor to the key->LED lab block. Two push-button keys
//  are synchronised and debounced. They then drive a 4-mode LED pattern sequencer:
//  key[0] steps the pattern and key[1] selects the mode.
//  Sits between the board keys and the LED bank in the lab top level.
// PARAMETERS
//  LED_W           10  number of LEDs driven (>=2)
//  DEBOUNCE_CYCLES  4  consecutive stable cycles needed to accept a key change (>=1)
//  BLINK_PERIOD     8  cycles per half-period in blink mode (>=1)
//  KEY_ACTIVE_LOW   0  1: raw key is 0 when pressed; inverted before synchroniser
// PORTS
//  clk        in   1      single clock
//  rst        in   1      synchronous reset, active-high
//  key        in   2      raw asynchronous buttons; [0]=step, [1]=mode
//  led        out  LED_W  registered LED pattern
//  mode       out  2      current mode: 0 count, 1 shift, 2 fill, 3 blink
//  key_press  out  2      one-cycle pulse per accepted press (debounced rising edge)
// BEHAVIOUR
//  Reset: led=0, mode=0, key_press=0. Synchronisers, debounced state, debounce
//   counters and blink timer are all cleared. Reset mid-bounce discards the bounce.
//  Input path per key: polarity fix -> 2-flop synchroniser (s) -> debouncer.
//   The debouncer keeps a debounced state (d) and a counter.
//   - Counter increments on every edge where s!=d.
//   - Any edge with s==d clears the counter.
//   - When the counter would reach DEBOUNCE_CYCLES, d<=s and the counter clears.
//  key_press[i] = d[i] & ~d_prev[i]. It is high for exactly one cycle; releases
//   give no pulse.
//  Latency: raw key rise held clean -> key_press high DEBOUNCE_CYCLES+2 edges later.
//   led/mode update on the following edge (DEBOUNCE_CYCLES+3 edges total).
//  Mode press (key_press[1]): mode <= mode+1, wrapping 3->0. led loads the init
//   value of the new mode:
//   count=0, shift=1 (bit0), fill=0, blink=all ones. Blink timer clears.
//  Step press (key_press[0]), by current mode:
//   count: led <= led+1 modulo 2^LED_W (all ones -> 0).
//   shift: one-hot rotate left; bit LED_W-1 -> bit0.
//   fill : led <= {led[LED_W-2:0],1'b1}; all ones -> 0 (LED_W+1 states).
//   blink: ignored.
//  Blink mode: the timer counts 0..BLINK_PERIOD-1.
//   On wrap, led <= ~led (all ones <-> all zeros). Independent of key[0].
//  Simultaneous key_press[1] and key_press[0] in one cycle: the mode press wins
//   and the step is dropped.
//  Both keys held continuously: no repeat; one pulse per accepted press.
//  led and mode change only on the events above, otherwise they hold.
// TESTING
//  T1 reset: rst=1 for 2 cycles with keys toggling -> led=0, mode=0, key_press=0.
//  T2 latency (DEBOUNCE_CYCLES=4): key[0] 0->1 held -> key_press[0] high
//     6 edges later for 1 cycle. led 0->1 on the next edge. Release gives no pulse.
//  T3 bounce: key[0] pulses 1 for 3 cycles, 0 for 1, then held 1 -> exactly one
//     press. Its timing is counted from the last 0->1 transition.
//  T4 wrap, LED_W=4: count mode, 16 presses -> led 0001..1111,0000.
//     Shift mode, 4 presses -> 0010,0100,1000,0001.
//     Fill mode, 5 presses -> 0001,0011,0111,1111,0000.
//  T5 mode cycling: 4 key[1] presses -> mode 1,2,3,0 with led 0001,0000,1111,0000.
//     In mode 3 with BLINK_PERIOD=8, led toggles every 8 cycles and key[0] has no effect.
//  T6 simultaneous: both keys rise together in mode 0 with led=0101 -> mode=1,
//     led=0001, no count step. KEY_ACTIVE_LOW=1 build repeats T2 with inverted key.

Source files
------------

// File: rtl/key_led_seq.sv
// Two-key front end (synchroniser + debouncer) feeding a 4-mode LED pattern sequencer.
// key[0] steps the current pattern, key[1] advances the mode.
module key_led_seq #(
  parameter int LED_W           = 10,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLINK_PERIOD    = 8,
  parameter bit KEY_ACTIVE_LOW  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       key,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic [1:0]       key_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_SHIFT = 2'd1,
    MODE_FILL  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;

  logic [1:0]       key_fix;
  logic [1:0]       sync_meta;
  logic [1:0]       sync_s;
  logic [1:0]       deb;
  logic [1:0]       deb_prev;
  logic [CW-1:0]    deb_cnt [2];
  logic [TW-1:0]    timer_q, timer_d;
  logic [LED_W-1:0] led_d;
  mode_t            state_q, state_d;

  assign key_fix = KEY_ACTIVE_LOW ? ~key : key;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync_s    <= '0;
      deb       <= '0;
      deb_prev  <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync_meta <= key_fix;
      sync_s    <= sync_meta;
      deb_prev  <= deb;
      // A change is accepted only after it has persisted for DEBOUNCE_CYCLES edges
      for (int i = 0; i < 2; i++) begin
        if (sync_s[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]     <= sync_s[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign key_press = deb & ~deb_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MODE_COUNT;
      led     <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      led     <= led_d;
      timer_q <= timer_d;
    end
  end

  // Mode press has priority; blink mode ignores step presses and free-runs its timer
  always_comb begin
    state_d = state_q;
    led_d   = led;
    timer_d = timer_q;
    if (key_press[1]) begin
      state_d = mode_t'(state_q + 2'd1);
      timer_d = '0;
      case (state_d)
        MODE_SHIFT: led_d = LED_W'(1);
        MODE_BLINK: led_d = '1;
        default:    led_d = '0;
      endcase
    end else if (state_q == MODE_BLINK) begin
      if (timer_q == TW'(BLINK_PERIOD - 1)) begin
        timer_d = '0;
        led_d   = ~led;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end else if (key_press[0]) begin
      case (state_q)
        MODE_COUNT: led_d = led + LED_W'(1);
        MODE_SHIFT: led_d = {led[LED_W-2:0], led[LED_W-1]};
        MODE_FILL:  led_d = (&led) ? '0 : {led[LED_W-2:0], 1'b1};
        default:    led_d = led;
      endcase
    end
  end

  assign mode = state_q;

endmodule
